gain_multiplier: RTL and testbench

Parametrised sequential shift-add gain stage for the pedal's audio sample path. It multiplies a signed sample by an unsigned fixed-point gain, then rounds and saturates the result back to sample width. Valid/ready handshakes on both sides let it sit between the ADC-side sample buffer and the memory controller's delay/reverb write path. It has a fixed, deterministic latency and an optional bypass mode.

---
 rtl/audio_dsp_pkg.sv | 21 ++
 rtl/sat_round.sv | 40 ++++
 rtl/gain_multiplier.sv | 116 +++++++++++
 tb/tb_gain_multiplier.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/audio_dsp_pkg.sv
// Shared definitions for the audio DSP blocks: FSM encodings and saturation limits.
package audio_dsp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULT  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Largest value representable in a w-bit signed word.
    function automatic longint SAT_MAX(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a w-bit signed word.
    function automatic longint SAT_MIN(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/sat_round.sv
// Round-half-toward-+inf then saturate a wide signed accumulator down to DATA_W bits.
module sat_round
    import audio_dsp_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned FRAC_BITS = 8
) (
    input  logic [ACC_W-1:0]  acc_i,
    output logic [DATA_W-1:0] data_o,
    output logic              sat_o
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam int unsigned HALF_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
    localparam logic signed [SUM_W-1:0] HALF =
        (FRAC_BITS > 0) ? (SUM_W'(1) << HALF_SH) : '0;
    localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'(SAT_MAX(DATA_W));
    localparam logic signed [SUM_W-1:0] MIN_V = SUM_W'(SAT_MIN(DATA_W));

    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] r;

    // Add half an LSB, drop the fraction bits, then clip to the output range.
    always_comb begin
        sum    = $signed({acc_i[ACC_W-1], acc_i}) + HALF;
        r      = sum >>> FRAC_BITS;
        data_o = r[DATA_W-1:0];
        sat_o  = 1'b0;
        if (r > MAX_V) begin
            data_o = MAX_V[DATA_W-1:0];
            sat_o  = 1'b1;
        end else if (r < MIN_V) begin
            data_o = MIN_V[DATA_W-1:0];
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/gain_multiplier.sv
// Sequential shift-add gain stage: signed sample times unsigned fixed-point gain,
// rounded and saturated back to sample width, with valid/ready on both sides.
module gain_multiplier
    import audio_dsp_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned GAIN_W    = 16,
    parameter int unsigned FRAC_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              bypass,
    input  logic [DATA_W-1:0] data_in,
    input  logic [GAIN_W-1:0] gain,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              out_sat
);

    localparam int unsigned ACC_W = DATA_W + GAIN_W;
    localparam int unsigned CNT_W = (GAIN_W > 1) ? $clog2(GAIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAIN_W - 1);

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   data_q;   // multiplicand, shifted left once per MULT cycle
    logic [GAIN_W-1:0]  gain_q;   // multiplier, shifted right once per MULT cycle
    logic [CNT_W-1:0]   cnt_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [DATA_W-1:0]  data_out_q;
    logic               out_sat_q;

    logic [DATA_W-1:0]  rnd_data;
    logic               rnd_sat;

    sat_round #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_sat_round (
        .acc_i  (acc_q),
        .data_o (rnd_data),
        .sat_o  (rnd_sat)
    );

    // Control FSM, shift-add datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            data_q      <= '0;
            gain_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q     <= {{GAIN_W{data_in[DATA_W-1]}}, data_in};
                        gain_q     <= gain;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (bypass) begin
                            data_out_q  <= data_in;
                            out_sat_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            state_q <= ST_MULT;
                        end
                    end
                end
                ST_MULT: begin
                    if (gain_q[0]) begin
                        acc_q <= acc_q + data_q;
                    end
                    data_q <= data_q << 1;
                    gain_q <= gain_q >> 1;
                    cnt_q  <= cnt_q + 1'b1;
                    // Always the full GAIN_W cycles, regardless of remaining gain bits.
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    data_out_q  <= rnd_data;
                    out_sat_q   <= rnd_sat;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_gain_multiplier.sv
// Directed, table-driven bench for gain_multiplier at default parameters.
module tb_gain_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        bypass;
    logic [15:0] data_in;
    logic [15:0] gain;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] data_out;
    logic        out_sat;

    int n_tests = 0;
    int n_fail  = 0;

    gain_multiplier #(
        .DATA_W    (16),
        .GAIN_W    (16),
        .FRAC_BITS (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bypass    (bypass),
        .data_in   (data_in),
        .gain      (gain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] din;
        logic [15:0] g;
        logic        byp;
        logic [15:0] exp_data;
        logic        exp_sat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one pair, wait for the result, check it, hold it for `hold` cycles, then drain.
    task automatic run_txn(input string name, input logic [15:0] din, input logic [15:0] g,
                           input logic byp, input logic [15:0] exp_data, input logic exp_sat,
                           input int exp_lat, input int hold);
        int wait_cnt;
        int lat;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 100) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
        data_in  = din;
        gain     = g;
        bypass   = byp;
        in_valid = 1'b1;
        @(posedge clk); #1;   // acceptance edge
        in_valid = 1'b0;
        // Scramble inputs; the block must ignore them until it is idle again.
        data_in  = ~din;
        gain     = ~g;
        bypass   = ~byp;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " data"}, {16'd0, data_out}, {16'd0, exp_data});
        check({name, " sat"}, {31'd0, out_sat}, {31'd0, exp_sat});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, " hold"}, {12'd0, out_valid, in_ready, out_sat, 1'b0, data_out},
                  {12'd0, 1'b1, 1'b0, exp_sat, 1'b0, exp_data});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, " drain"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        int quiet;
        vecs[0]  = '{16'h1234, 16'h0100, 1'b0, 16'h1234, 1'b0};
        vecs[1]  = '{16'h8000, 16'h0100, 1'b0, 16'h8000, 1'b0};
        vecs[2]  = '{16'h4000, 16'h0200, 1'b0, 16'h7FFF, 1'b1};
        vecs[3]  = '{16'h8000, 16'h0200, 1'b0, 16'h8000, 1'b1};
        vecs[4]  = '{16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
        vecs[5]  = '{16'h0003, 16'h0080, 1'b0, 16'h0002, 1'b0};
        vecs[6]  = '{16'hFFFD, 16'h0080, 1'b0, 16'hFFFF, 1'b0};
        vecs[7]  = '{16'h0001, 16'h0040, 1'b0, 16'h0000, 1'b0};
        vecs[8]  = '{16'h7FFF, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[9]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1};
        vecs[10] = '{16'h8000, 16'hFFFF, 1'b0, 16'h8000, 1'b1};
        vecs[11] = '{16'hFFFF, 16'h0180, 1'b0, 16'hFFFF, 1'b0};
        vecs[12] = '{16'hABCD, 16'h0000, 1'b1, 16'hABCD, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        bypass    = 1'b0;
        data_in   = '0;
        gain      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outs", {12'd0, out_valid, in_ready, out_sat, 1'b0, data_out}, 32'h0004_0000);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_txn($sformatf("vec%0d", i), vecs[i].din, vecs[i].g, vecs[i].byp,
                    vecs[i].exp_data, vecs[i].exp_sat, vecs[i].byp ? 0 : 17, 0);
        end

        // Backpressure: result must stay frozen while downstream stalls.
        run_txn("backpressure", 16'h0123, 16'h0300, 1'b0, 16'h0369, 1'b0, 17, 10);

        // Reset in MULT cycle 5 aborts the operation.
        data_in  = 16'h1000;
        gain     = 16'h0100;
        bypass   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort outs", {12'd0, out_valid, in_ready, out_sat, 1'b0, data_out}, 32'h0004_0000);
        quiet = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) quiet++;
        end
        check("abort no valid", quiet, 0);
        run_txn("after abort", 16'h0100, 16'h0300, 1'b0, 16'h0300, 1'b0, 17, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
